// File: rtl/xg_timing_pkg.sv
// xg_timing_pkg: shared constants and types for the gen3 raster timing generator.
// Defaults describe VGA 640x480@60 on a 25 MHz pixel clock.
package xg_timing_pkg;

    localparam int XG_CW = 10;

    localparam int XG_H_ACTIVE = 640;
    localparam int XG_H_FP     = 16;
    localparam int XG_H_SYNC   = 96;
    localparam int XG_H_BP     = 48;

    localparam int XG_V_ACTIVE = 480;
    localparam int XG_V_FP     = 10;
    localparam int XG_V_SYNC   = 2;
    localparam int XG_V_BP     = 33;

    localparam int XG_DRAW_DELAY     = 12;
    localparam int XG_PREFETCH_LINES = 14;

    typedef logic [XG_CW-1:0] xg_coord_t;

    // Signals carried from the render side to the VGA driver side.
    typedef struct packed {
        logic vde;
        logic hsync;
        logic vsync;
    } xg_draw_sig_t;

    // Inactive draw state: no video enable, both syncs deasserted (high).
    localparam xg_draw_sig_t XG_DRAW_IDLE = '{vde: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // Total period of one axis from its active, front porch, sync and back porch spans.
    function automatic int xg_total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/xg_delay_line.sv
// xg_delay_line: DEPTH-stage shift register with a synchronous flush that loads
// every stage with RST_VAL. Output is the last stage, so latency is DEPTH clocks.
module xg_delay_line #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 12,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_25,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per clock; flush loads every stage with the idle value.
    // NOTE: every stage is flushed, not just the head, because a stale stage would
    // leak an old vde/sync value to the output after reset or a timing_en pause.
    always_ff @(posedge clk_25) begin
        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/xg_timing_gen3.sv
// xg_timing_gen3: parametrised raster timing generator (pixel/line counters, render
// and draw windows, sync, prefetch window, frame counter, line-compare IRQ).
// Draw outputs lag the counters by DRAW_DELAY clocks through one shared delay line.
// Build option: define XG_TIMING_LINE_IRQ_EN to include the line-compare IRQ;
// otherwise line_irq is tied low and irq_line_cmp is ignored.
// H_TOTAL and V_TOTAL must fit in CW bits; DRAW_DELAY must be 1..31.
module xg_timing_gen3
    import xg_timing_pkg::*;
#(
    parameter int CW             = XG_CW,
    parameter int H_ACTIVE       = XG_H_ACTIVE,
    parameter int H_FP           = XG_H_FP,
    parameter int H_SYNC         = XG_H_SYNC,
    parameter int H_BP           = XG_H_BP,
    parameter int V_ACTIVE       = XG_V_ACTIVE,
    parameter int V_FP           = XG_V_FP,
    parameter int V_SYNC         = XG_V_SYNC,
    parameter int V_BP           = XG_V_BP,
    parameter int DRAW_DELAY     = XG_DRAW_DELAY,
    parameter int PREFETCH_LINES = XG_PREFETCH_LINES
) (
    input  logic          clk_25,
    input  logic          rst,
    input  logic          timing_en,
    output logic [CW-1:0] col,
    output logic [CW-1:0] line,
    output logic          render_area,
    output logic          render_rows,
    output logic          draw_area,
    output logic          draw_hsync,
    output logic          draw_vsync,
    output logic          line_end,
    output logic          frame_end,
    output logic          prefetch_rows,
    output logic [7:0]    frame_count,
    input  logic [CW-1:0] irq_line_cmp,
    output logic          line_irq
);

    localparam int H_TOTAL = xg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = xg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] PF_START = CW'(V_TOTAL - PREFETCH_LINES);
    localparam bit            PF_ON    = (PREFETCH_LINES != 0);

    logic [CW-1:0] r_col, r_line;
    logic          r_render_area, r_render_rows, r_hsync_raw, r_vsync_raw;
    logic          r_line_end, r_frame_end, r_prefetch_rows;
    logic [7:0]    r_frame_count;

    logic [CW-1:0] w_col_nxt, w_line_nxt;
    logic          w_flush;
    xg_draw_sig_t  w_draw_in, w_draw_out;

    assign w_flush = rst || !timing_en;

    // Next counter position when running: column wraps into a line step, line wraps at frame end.
    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        w_col_nxt  = r_col + 1'b1;
        w_line_nxt = r_line;
        if (r_col == H_LAST) begin
            w_col_nxt  = '0;
            w_line_nxt = (r_line == V_LAST) ? '0 : r_line + 1'b1;
        end
    end

    // Counters plus window flags decoded from the next position, so flags match col/line with zero lag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_25) begin
        if (w_flush) begin
            r_col           <= '0;
            r_line          <= '0;
            r_render_area   <= 1'b1;
            r_render_rows   <= 1'b1;
            r_hsync_raw     <= 1'b1;
            r_vsync_raw     <= 1'b1;
            r_line_end      <= 1'b0;
            r_frame_end     <= 1'b0;
            r_prefetch_rows <= 1'b0;
        end else begin
            r_col           <= w_col_nxt;
            r_line          <= w_line_nxt;
            r_render_area   <= (w_col_nxt < H_ACT) && (w_line_nxt < V_ACT);
            r_render_rows   <= (w_line_nxt < V_ACT);
            r_hsync_raw     <= !((w_col_nxt >= HS_START) && (w_col_nxt < HS_END));
            r_vsync_raw     <= !((w_line_nxt >= VS_START) && (w_line_nxt < VS_END));
            r_line_end      <= (w_col_nxt == H_LAST);
            r_frame_end     <= (w_col_nxt == H_LAST) && (w_line_nxt == V_LAST);
            r_prefetch_rows <= PF_ON && (w_line_nxt >= PF_START);
        end
    end

    // Frame counter: cleared only by rst, frozen while timing_en is low, steps as the frame wraps.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_frame_count <= 8'd0;
        end else if (timing_en && r_frame_end) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

`ifdef XG_TIMING_LINE_IRQ_EN
    logic r_line_irq;

    // One-clock pulse at hblank start of the line selected by irq_line_cmp.
    always_ff @(posedge clk_25) begin
        if (w_flush) begin
            r_line_irq <= 1'b0;
        end else begin
            r_line_irq <= (w_col_nxt == H_ACT) && (w_line_nxt == irq_line_cmp);
        end
    end

    assign line_irq = r_line_irq;
`else
    logic w_unused_cmp;
    assign w_unused_cmp = ^irq_line_cmp;
    assign line_irq     = 1'b0;
`endif

    // Raw syncs and render window travel together so the draw side stays mutually aligned.
    assign w_draw_in = '{vde: r_render_area, hsync: r_hsync_raw, vsync: r_vsync_raw};

    xg_delay_line #(
        .W       ($bits(xg_draw_sig_t)),
        .DEPTH   (DRAW_DELAY),
        .RST_VAL (XG_DRAW_IDLE)
    ) u_draw_dly (
        .clk_25  (clk_25),
        .i_flush (w_flush),
        .i_din   (w_draw_in),
        .o_dout  (w_draw_out)
    );

    assign col           = r_col;
    assign line          = r_line;
    assign render_area   = r_render_area;
    assign render_rows   = r_render_rows;
    assign draw_area     = w_draw_out.vde;
    assign draw_hsync    = w_draw_out.hsync;
    assign draw_vsync    = w_draw_out.vsync;
    assign line_end      = r_line_end;
    assign frame_end     = r_frame_end;
    assign prefetch_rows = r_prefetch_rows;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_xg_timing_gen3.sv
// tb_xg_timing_gen3: scoreboard bench for xg_timing_gen3.
// DUT 0 uses the default 640x480 timing, DUT 1 a tiny 24x8 raster with DRAW_DELAY=1.
// Expected values are hand-computed and queued by absolute cycle; a negedge monitor
// pops and compares them as the DUTs reach each cycle.
module tb_xg_timing_gen3;

`ifdef XG_TIMING_LINE_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    localparam int B0 = 3;          // cycle index of clock 0 (first counted cycle after rst)
    localparam int BB = B0 + 205;   // DUT 1 clock 0 after its timing_en pause
    localparam int BA = B0 + 3105;  // DUT 0 clock 0 after its timing_en pause

    typedef enum int {S_COL, S_LINE, S_RA, S_RR, S_DA, S_HS, S_VS, S_LE, S_FE, S_PF, S_FC, S_IRQ} sel_e;

    typedef struct {
        int    cyc;
        int    dut;
        sel_e  sel;
        int    exp;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    logic       clk_25 = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [9:0] cmp_a, cmp_b;

    logic [9:0] a_col, a_line, b_col, b_line;
    logic       a_ra, a_rr, a_da, a_hs, a_vs, a_le, a_fe, a_pf, a_irq;
    logic       b_ra, b_rr, b_da, b_hs, b_vs, b_le, b_fe, b_pf, b_irq;
    logic [7:0] a_fc, b_fc;

    always #20 clk_25 = ~clk_25;

    xg_timing_gen3 u_dut_a (
        .clk_25        (clk_25),
        .rst           (rst),
        .timing_en     (en_a),
        .col           (a_col),
        .line          (a_line),
        .render_area   (a_ra),
        .render_rows   (a_rr),
        .draw_area     (a_da),
        .draw_hsync    (a_hs),
        .draw_vsync    (a_vs),
        .line_end      (a_le),
        .frame_end     (a_fe),
        .prefetch_rows (a_pf),
        .frame_count   (a_fc),
        .irq_line_cmp  (cmp_a),
        .line_irq      (a_irq)
    );

    xg_timing_gen3 #(
        .H_ACTIVE       (16),
        .H_FP           (2),
        .H_SYNC         (3),
        .H_BP           (3),
        .V_ACTIVE       (4),
        .V_FP           (1),
        .V_SYNC         (1),
        .V_BP           (2),
        .DRAW_DELAY     (1),
        .PREFETCH_LINES (2)
    ) u_dut_b (
        .clk_25        (clk_25),
        .rst           (rst),
        .timing_en     (en_b),
        .col           (b_col),
        .line          (b_line),
        .render_area   (b_ra),
        .render_rows   (b_rr),
        .draw_area     (b_da),
        .draw_hsync    (b_hs),
        .draw_vsync    (b_vs),
        .line_end      (b_le),
        .frame_end     (b_fe),
        .prefetch_rows (b_pf),
        .frame_count   (b_fc),
        .irq_line_cmp  (cmp_b),
        .line_irq      (b_irq)
    );

    function automatic int get_val(input int dut, input sel_e s);
        if (dut == 0) begin
            case (s)
                S_COL:   return int'(a_col);
                S_LINE:  return int'(a_line);
                S_RA:    return int'(a_ra);
                S_RR:    return int'(a_rr);
                S_DA:    return int'(a_da);
                S_HS:    return int'(a_hs);
                S_VS:    return int'(a_vs);
                S_LE:    return int'(a_le);
                S_FE:    return int'(a_fe);
                S_PF:    return int'(a_pf);
                S_FC:    return int'(a_fc);
                default: return int'(a_irq);
            endcase
        end
        case (s)
            S_COL:   return int'(b_col);
            S_LINE:  return int'(b_line);
            S_RA:    return int'(b_ra);
            S_RR:    return int'(b_rr);
            S_DA:    return int'(b_da);
            S_HS:    return int'(b_hs);
            S_VS:    return int'(b_vs);
            S_LE:    return int'(b_le);
            S_FE:    return int'(b_fe);
            S_PF:    return int'(b_pf);
            S_FC:    return int'(b_fc);
            default: return int'(b_irq);
        endcase
    endfunction

    // Insert an expectation keeping the queue ordered by cycle.
    task automatic push(input int dut, input sel_e s, input int c, input int e, input string nm);
        exp_t x;
        int   i;
        x.cyc = c; x.dut = dut; x.sel = s; x.exp = e; x.name = nm;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].cyc > c) i--;
        sb_q.insert(i, x);
    endtask

    // Idle state shared by reset and timing_en-low cycles.
    task automatic push_idle(input int dut, input int c, input int fc);
        push(dut, S_COL, c, 0, "idle_col");
        push(dut, S_LINE, c, 0, "idle_line");
        push(dut, S_RA, c, 1, "idle_render_area");
        push(dut, S_RR, c, 1, "idle_render_rows");
        push(dut, S_DA, c, 0, "idle_draw_area");
        push(dut, S_HS, c, 1, "idle_draw_hsync");
        push(dut, S_VS, c, 1, "idle_draw_vsync");
        push(dut, S_LE, c, 0, "idle_line_end");
        push(dut, S_FE, c, 0, "idle_frame_end");
        push(dut, S_PF, c, 0, "idle_prefetch");
        push(dut, S_FC, c, fc, "idle_frame_count");
        push(dut, S_IRQ, c, 0, "idle_line_irq");
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    always @(posedge clk_25) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk_25) begin : monitor
        exp_t e;
        int   act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_total++;
            act = get_val(e.dut, e.sel);
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: dut%0d due cycle %0d but reached at %0d", e.name, e.dut, e.cyc, cyc);
            end else if (act != e.exp) begin
                n_bad++;
                $display("FAIL %s: dut%0d cycle %0d got %0d want %0d", e.name, e.dut, cyc, act, e.exp);
            end
        end
    end

    initial begin : watchdog
        #(60000 * 40);
        $display("FAIL watchdog: run did not complete, pending=%0d", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
        cmp_a = 10'd1; cmp_b = 10'd9;

        // Reset state on both DUTs.
        push_idle(0, 2, 0);
        push_idle(1, 2, 0);

        // DUT 0: counters, windows, hsync lag, line compare.
        push(0, S_COL, B0 + 0, 0, "a_col_c0");
        push(0, S_COL, B0 + 799, 799, "a_col_c799");
        push(0, S_LINE, B0 + 799, 0, "a_line_c799");
        push(0, S_LE, B0 + 799, 1, "a_line_end_c799");
        push(0, S_FE, B0 + 799, 0, "a_frame_end_c799");
        push(0, S_COL, B0 + 800, 0, "a_col_c800");
        push(0, S_LINE, B0 + 800, 1, "a_line_c800");
        push(0, S_LE, B0 + 800, 0, "a_line_end_c800");
        push(0, S_RA, B0 + 639, 1, "a_render_area_c639");
        push(0, S_RA, B0 + 640, 0, "a_render_area_c640");
        push(0, S_DA, B0 + 11, 0, "a_draw_area_c11");
        push(0, S_DA, B0 + 12, 1, "a_draw_area_c12");
        push(0, S_DA, B0 + 651, 1, "a_draw_area_c651");
        push(0, S_DA, B0 + 652, 0, "a_draw_area_c652");
        push(0, S_HS, B0 + 667, 1, "a_hsync_c667");
        push(0, S_HS, B0 + 668, 0, "a_hsync_c668");
        push(0, S_HS, B0 + 763, 0, "a_hsync_c763");
        push(0, S_HS, B0 + 764, 1, "a_hsync_c764");
        push(0, S_RR, B0 + 1000, 1, "a_render_rows_c1000");
        push(0, S_PF, B0 + 1000, 0, "a_prefetch_c1000");
        push(0, S_VS, B0 + 1000, 1, "a_vsync_c1000");
        push(0, S_IRQ, B0 + 1439, 0, "a_irq_l1_c639");
        push(0, S_IRQ, B0 + 1440, IRQ_EXP, "a_irq_l1_c640");
        push(0, S_IRQ, B0 + 1441, 0, "a_irq_l1_c641");
        push(0, S_IRQ, B0 + 3039, 0, "a_irq_l3_c639");
        push(0, S_IRQ, B0 + 3040, IRQ_EXP, "a_irq_l3_c640");
        push(0, S_COL, B0 + 3100, 700, "a_col_prepause");
        push(0, S_LINE, B0 + 3100, 3, "a_line_prepause");
        push(0, S_HS, B0 + 3100, 0, "a_hsync_prepause");
        push_idle(0, B0 + 3103, 0);
        push(0, S_COL, BA + 0, 0, "a_col_resume");
        push(0, S_LINE, BA + 0, 0, "a_line_resume");
        push(0, S_RA, BA + 0, 1, "a_render_area_resume");
        push(0, S_COL, BA + 1, 1, "a_col_resume_c1");
        push(0, S_DA, BA + 11, 0, "a_draw_area_resume_c11");
        push(0, S_DA, BA + 12, 1, "a_draw_area_resume_c12");
        push(0, S_HS, BA + 667, 1, "a_hsync_resume_c667");
        push(0, S_HS, BA + 668, 0, "a_hsync_resume_c668");

        // DUT 1: small raster, full frame, frame counter wrap.
        push(1, S_COL, B0 + 0, 0, "b_col_c0");
        push(1, S_DA, B0 + 0, 0, "b_draw_area_c0");
        push(1, S_DA, B0 + 1, 1, "b_draw_area_c1");
        push(1, S_DA, B0 + 16, 1, "b_draw_area_c16");
        push(1, S_DA, B0 + 17, 0, "b_draw_area_c17");
        push(1, S_HS, B0 + 18, 1, "b_hsync_c18");
        push(1, S_HS, B0 + 19, 0, "b_hsync_c19");
        push(1, S_HS, B0 + 21, 0, "b_hsync_c21");
        push(1, S_HS, B0 + 22, 1, "b_hsync_c22");
        push(1, S_LE, B0 + 23, 1, "b_line_end_c23");
        push(1, S_COL, B0 + 24, 0, "b_col_c24");
        push(1, S_LINE, B0 + 24, 1, "b_line_c24");
        push(1, S_RR, B0 + 95, 1, "b_render_rows_l3");
        push(1, S_RR, B0 + 96, 0, "b_render_rows_l4");
        push(1, S_VS, B0 + 120, 1, "b_vsync_l5_c0");
        push(1, S_VS, B0 + 121, 0, "b_vsync_l5_c1");
        push(1, S_VS, B0 + 144, 0, "b_vsync_l6_c0");
        push(1, S_VS, B0 + 145, 1, "b_vsync_l6_c1");
        push(1, S_PF, B0 + 143, 0, "b_prefetch_l5");
        push(1, S_PF, B0 + 144, 1, "b_prefetch_l6");
        push(1, S_FE, B0 + 190, 0, "b_frame_end_c190");
        push(1, S_PF, B0 + 191, 1, "b_prefetch_l7");
        push(1, S_FE, B0 + 191, 1, "b_frame_end_c191");
        push(1, S_FC, B0 + 191, 0, "b_frame_count_c191");
        push(1, S_LINE, B0 + 191, 7, "b_line_c191");
        push(1, S_COL, B0 + 191, 23, "b_col_c191");
        push(1, S_FC, B0 + 192, 1, "b_frame_count_c192");
        push(1, S_PF, B0 + 192, 0, "b_prefetch_c192");
        push(1, S_LINE, B0 + 192, 0, "b_line_c192");
        for (int l = 0; l < 8; l++) begin
            push(1, S_IRQ, B0 + 16 + 24 * l, 0, "b_irq_out_of_range");
        end
        push(1, S_COL, B0 + 200, 8, "b_col_prepause");
        push(1, S_DA, B0 + 200, 1, "b_draw_area_prepause");
        push(1, S_FC, B0 + 200, 1, "b_frame_count_prepause");
        push_idle(1, B0 + 203, 1);
        push(1, S_COL, BB + 0, 0, "b_col_resume");
        push(1, S_LINE, BB + 0, 0, "b_line_resume");
        push(1, S_RA, BB + 0, 1, "b_render_area_resume");
        push(1, S_FC, BB + 0, 1, "b_frame_count_resume");
        push(1, S_COL, BB + 1, 1, "b_col_resume_c1");
        push(1, S_FC, BB + 254 * 192 - 1, 254, "b_frame_count_254");
        push(1, S_FC, BB + 254 * 192, 255, "b_frame_count_255");
        push(1, S_FC, BB + 255 * 192 - 1, 255, "b_frame_count_255_end");
        push(1, S_FE, BB + 255 * 192 - 1, 1, "b_frame_end_wrap");
        push(1, S_FC, BB + 255 * 192, 0, "b_frame_count_wrap");
        push(1, S_COL, BB + 255 * 192, 0, "b_col_wrap");
        push(1, S_LINE, BB + 255 * 192, 0, "b_line_wrap");

        // Drive the input timeline.
        wait_until(B0);
        rst = 1'b0;
        wait_until(B0 + 200);
        en_b = 1'b0;
        wait_until(B0 + 205);
        en_b = 1'b1;
        wait_until(B0 + 1500);
        cmp_a = 10'd3;
        wait_until(B0 + 3100);
        en_a = 1'b0;
        wait_until(B0 + 3105);
        en_a = 1'b1;
        wait_until(BB + 255 * 192 + 4);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL %s: dut%0d cycle %0d never checked, want %0d", e.name, e.dut, e.cyc, e.exp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
